unit_l_seq: RTL and testbench

Sequencing and result-holding stage wrapped around the 32-bit logic unit `unit_L`. Accepts one operation per valid/ready handshake, registers operands and select, drives `unit_L`, captures its output into a held result register with a ready/valid output handshake, and keeps an accumulator so consecutive operations can chain on the previous result. Sits between the instruction/operand source and the result consumer of the logic datapath.

---
 rtl/unit_l_seq_pkg.sv | 36 +++
 rtl/unit_l_seq_if.sv | 26 ++
 rtl/unit_l_seq_unit_l.sv | 20 ++
 rtl/unit_l_seq.sv | 79 +++++++
 tb/tb_unit_l_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/unit_l_seq_pkg.sv
// Shared types for the logic-unit sequencer: op/state encodings and the
// registered request record.
package unit_l_seq_pkg;
  localparam int UNIT_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [UNIT_W-1:0] a;
    logic [UNIT_W-1:0] b;
  } req_t;

  // Operand a comes from the accumulator when chaining.
  function automatic req_t mk_req(input logic [1:0] op, input logic chain,
                                  input logic [UNIT_W-1:0] a,
                                  input logic [UNIT_W-1:0] acc,
                                  input logic [UNIT_W-1:0] b);
    req_t r;
    r.op = op_e'(op);
    r.a  = chain ? acc : a;
    r.b  = b;
    return r;
  endfunction
endpackage

// File: rtl/unit_l_seq_if.sv
// Request/result handshake bundle between operand source, sequencer and
// result consumer.
interface unit_l_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_chain;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_op;
  logic             out_zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, in_op, in_chain, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, acc
  );

  modport slave (
    input  in_valid, in_op, in_chain, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, acc
  );
endinterface

// File: rtl/unit_l_seq_unit_l.sv
// 32-bit bitwise logic unit: S1/S0 = 01 AND, 10 OR, 11 XOR, 00 passes a.
module unit_l
  import unit_l_seq_pkg::*;
(
  input  logic              s1,
  input  logic              s0,
  input  logic [UNIT_W-1:0] a,
  input  logic [UNIT_W-1:0] b,
  output logic [UNIT_W-1:0] y
);
  always_comb begin
    y = a;
    case ({s1, s0})
      2'b01:   y = a & b;
      2'b10:   y = a | b;
      2'b11:   y = a ^ b;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/unit_l_seq.sv
// Sequencer around unit_l: registers one request per handshake, holds the
// result until consumed and keeps an accumulator for chained operations.
module unit_l_seq
  import unit_l_seq_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  unit_l_seq_if.slave bus
);
  // unit_l is fixed at 32 bits; WIDTH must equal UNIT_W.
  state_e           state;
  req_t             req_r;
  logic [WIDTH-1:0] acc_r, result_r, ul_out, res;
  op_e              op_r;
  logic             zero_r, valid_r;

  unit_l u_l (
    .s1 (req_r.op[1]),
    .s0 (req_r.op[0]),
    .a  (req_r.a),
    .b  (req_r.b),
    .y  (ul_out)
  );

  assign res = (req_r.op == OP_LOAD) ? req_r.b : ul_out;

  // In DONE the slot frees in the same cycle the consumer takes the result.
  assign bus.in_ready   = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign bus.out_valid  = valid_r;
  assign bus.out_result = result_r;
  assign bus.out_op     = op_r;
  assign bus.out_zero   = zero_r;
  assign bus.acc        = acc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_r    <= '0;
      acc_r    <= ACC_INIT;
      result_r <= '0;
      op_r     <= OP_LOAD;
      zero_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            req_r <= mk_req(bus.in_op, bus.in_chain, bus.in_a, acc_r, bus.in_b);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_r <= res;
          acc_r    <= res;
          op_r     <= req_r.op;
          zero_r   <= (res == '0);
          valid_r  <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            // acc already holds this result, so a chained request sees it.
            if (bus.in_valid) begin
              req_r <= mk_req(bus.in_op, bus.in_chain, bus.in_a, acc_r, bus.in_b);
              state <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unit_l_seq.sv
// Directed bench for unit_l_seq: vector table plus hand sequences for
// back-to-back, stall and mid-operation reset.
module tb_unit_l_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unit_l_seq_if #(.WIDTH(32)) bus();

  unit_l_seq #(.WIDTH(32), .ACC_INIT(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic        chain;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;
  int hs = 0;

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) hs <= hs + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic ch,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_chain = ch;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  // Starts and ends at a negedge with the FSM idle and out_ready high.
  task automatic run_vec(input int i);
    drive(1'b1, vecs[i].op, vecs[i].chain, vecs[i].a, vecs[i].b);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk($sformatf("v%0d exec_in_ready", i), {31'b0, bus.in_ready}, 32'd0);
    chk($sformatf("v%0d exec_out_valid", i), {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
    chk($sformatf("v%0d result", i), bus.out_result, vecs[i].res);
    chk($sformatf("v%0d acc", i), bus.acc, vecs[i].res);
    chk($sformatf("v%0d op", i), {30'b0, bus.out_op}, {30'b0, vecs[i].op});
    chk($sformatf("v%0d zero", i), {31'b0, bus.out_zero}, {31'b0, vecs[i].zero});
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d released", i), {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int hs0;
    logic [31:0] r0;
    vecs[0] = '{2'b01, 1'b0, 32'hDC754CD2, 32'h4124F055, 32'h40244050, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[2] = '{2'b11, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    vecs[3] = '{2'b00, 1'b0, 32'h00000000, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 32'hFFFFFFFF, 32'h0000FFFF, 32'hA5A5FFFF, 1'b0};
    vecs[5] = '{2'b11, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h5A5A0000, 1'b0};

    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst result", bus.out_result, 32'h0);
    chk("rst op", {30'b0, bus.out_op}, 32'h0);
    chk("rst zero", {31'b0, bus.out_zero}, 32'd0);
    chk("rst acc", bus.acc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Back-to-back OR, XOR, chained AND with out_ready held high.
    hs0 = hs;
    drive(1'b1, 2'b10, 1'b0, 32'hDC754CD2, 32'h4124F055);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 2'b11, 1'b0, 32'hDC754CD2, 32'h4124F055);
    chk("b2b exec1 valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b or valid", {31'b0, bus.out_valid}, 32'd1);
    chk("b2b or result", bus.out_result, 32'hDD75FCD7);
    chk("b2b done in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("b2b exec2 valid", {31'b0, bus.out_valid}, 32'd0);
    drive(1'b1, 2'b01, 1'b1, 32'h00000000, 32'hFFFF0000);
    @(posedge clk); @(negedge clk);
    chk("b2b xor result", bus.out_result, 32'h9D51BC87);
    chk("b2b xor valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("chain result", bus.out_result, 32'h9D510000);
    chk("chain acc", bus.acc, 32'h9D510000);
    @(posedge clk); @(negedge clk);
    chk("b2b handshakes", hs - hs0, 32'd3);

    // Stall in DONE with out_ready low while inputs wiggle.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    hs0 = hs;
    r0 = bus.out_result;
    chk("stall result", r0, 32'h0F0F0F0F);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom, $urandom);
      @(posedge clk); @(negedge clk);
      chk($sformatf("stall%0d result", k), bus.out_result, 32'h0F0F0F0F);
      chk($sformatf("stall%0d acc", k), bus.acc, 32'h0F0F0F0F);
      chk($sformatf("stall%0d valid", k), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("stall%0d in_ready", k), {31'b0, bus.in_ready}, 32'd0);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("stall handshakes", hs - hs0, 32'd1);
    chk("stall released", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset while in EXEC.
    drive(1'b1, 2'b11, 1'b0, 32'h00000001, 32'h00000002);
    @(posedge clk);
    #1 drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("pre-rst in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("arst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst result", bus.out_result, 32'h0);
    chk("arst acc", bus.acc, 32'h0);
    chk("arst zero", {31'b0, bus.out_zero}, 32'd0);
    chk("arst op", {30'b0, bus.out_op}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hs0 = hs;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst%0d valid", k), {31'b0, bus.out_valid}, 32'd0);
    end
    chk("post-rst handshakes", hs - hs0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
